// File: rtl/io_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : io_cmd_sequencer
// Brief    : Issues decoded commands to the IO module, waits for completion
//            and streams the ASCII response line over a valid/ready byte port.
//            Optional IO timeout is enabled by defining IO_CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module io_cmd_sequencer #(
    parameter int INPUT_DATA_SIZE    = 52,
    parameter int INSTRUCTION_SIZE   = 3,
    parameter int SIZE_WORD_REGISTER = 5,
    parameter int AUXILIAR_SIZE      = INPUT_DATA_SIZE - INSTRUCTION_SIZE - SIZE_WORD_REGISTER,
    parameter int IO_OUTPUT_SIZE     = 8,
    parameter int ARM_CYCLES         = 2,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INPUT_DATA_SIZE-1:0]    control_value,
    input  logic                          valid_control_value,
    output logic                          control_ready,
    output logic [INSTRUCTION_SIZE-1:0]   instrucction,
    output logic [SIZE_WORD_REGISTER-1:0] register,
    output logic [AUXILIAR_SIZE-1:0]      auxiliar_register,
    output logic                          valid_instrucction,
    input  logic                          busy_io_module,
    input  logic [IO_OUTPUT_SIZE-1:0]     result_input_io,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [7:0]                    reject_count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_ARM   = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_SEND  = 3'd4;

    localparam logic [2:0] c_RSP_OK  = 3'd0;
    localparam logic [2:0] c_RSP_HEX = 3'd1;
    localparam logic [2:0] c_RSP_BIT = 3'd2;
    localparam logic [2:0] c_RSP_TO  = 3'd3;
    localparam logic [2:0] c_RSP_BSY = 3'd4;

    localparam int                 c_HEX_DIGITS = IO_OUTPUT_SIZE / 4;
    localparam int                 c_ARM_W      = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [c_ARM_W-1:0] c_ARM_LAST   = c_ARM_W'(ARM_CYCLES - 1);

    // Empty on legal configurations; present so bad parameter sets stand out in elaboration logs.
    if (TIMEOUT_CYCLES < 1 || ARM_CYCLES < 1 || (IO_OUTPUT_SIZE % 4) != 0) begin : g_param_guard_invalid
    end

    logic [2:0]                    r_state;
    logic                          r_control_ready;
    logic [INSTRUCTION_SIZE-1:0]   r_instr;
    logic [SIZE_WORD_REGISTER-1:0] r_register;
    logic [AUXILIAR_SIZE-1:0]      r_aux;
    logic                          r_valid_instr;
    logic [c_ARM_W-1:0]            r_arm_cnt;
    logic [IO_OUTPUT_SIZE-1:0]     r_result;
    logic [2:0]                    r_kind;
    logic [3:0]                    r_idx;
    logic [7:0]                    r_tx_data;
    logic                          r_tx_valid;
    logic                          r_valid_q;
    logic                          r_bsy_pending;
    logic [7:0]                    r_reject_count;
    logic [2:0]                    w_op;
    logic [2:0]                    w_kind;
    logic                          w_reject;

`ifdef IO_CMD_TIMEOUT_EN
    localparam int                c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TO_W-1:0]            r_wait_cnt;
`endif

    function automatic logic [7:0] f_rsp_byte(input logic [2:0] kind, input logic [3:0] idx,
                                              input logic [IO_OUTPUT_SIZE-1:0] res);
        logic [7:0]                b;
        logic [IO_OUTPUT_SIZE-1:0] sh;
        logic [3:0]                nib;
        b   = 8'h00;
        sh  = '0;
        nib = 4'h0;
        case (kind)
            c_RSP_OK:  b = (idx == 4'd0) ? 8'h4F : (idx == 4'd1) ? 8'h4B : (idx == 4'd2) ? 8'h0D : 8'h0A;
            c_RSP_BIT: b = (idx == 4'd0) ? 8'h20 : (idx == 4'd1) ? (res[0] ? 8'h31 : 8'h30) :
                           (idx == 4'd2) ? 8'h0D : 8'h0A;
            c_RSP_TO:  b = (idx == 4'd0) ? 8'h54 : (idx == 4'd1) ? 8'h4F : (idx == 4'd2) ? 8'h0D : 8'h0A;
            c_RSP_BSY: b = (idx == 4'd0) ? 8'h42 : (idx == 4'd1) ? 8'h53 : (idx == 4'd2) ? 8'h59 :
                           (idx == 4'd3) ? 8'h0D : 8'h0A;
            default: begin
                if (int'(idx) < c_HEX_DIGITS) begin
                    sh  = res >> (4 * (c_HEX_DIGITS - 1 - int'(idx)));
                    nib = sh[3:0];
                    b   = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
                end else begin
                    b = (int'(idx) == c_HEX_DIGITS) ? 8'h0D : 8'h0A;
                end
            end
        endcase
        return b;
    endfunction

    function automatic logic [3:0] f_rsp_last(input logic [2:0] kind);
        logic [3:0] last;
        case (kind)
            c_RSP_HEX: last = 4'(c_HEX_DIGITS + 1);
            c_RSP_BSY: last = 4'd4;
            default:   last = 4'd3;
        endcase
        return last;
    endfunction

    assign w_op = r_instr[INSTRUCTION_SIZE-1 -: 3];

    always_comb begin
        w_kind = c_RSP_BIT;
        if (!w_op[2] || w_op == 3'b111) begin
            w_kind = c_RSP_OK;
        end else if (w_op == 3'b110) begin
            w_kind = c_RSP_HEX;
        end
    end

    // One reject per run of valid cycles while the sequencer is occupied.
    assign w_reject = valid_control_value & ~r_control_ready & ~r_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_control_ready <= 1'b1;
            r_instr         <= '0;
            r_register      <= '0;
            r_aux           <= '0;
            r_valid_instr   <= 1'b0;
            r_arm_cnt       <= '0;
            r_result        <= '0;
            r_kind          <= c_RSP_OK;
            r_idx           <= 4'd0;
            r_tx_data       <= 8'h00;
            r_tx_valid      <= 1'b0;
            r_valid_q       <= 1'b0;
            r_bsy_pending   <= 1'b0;
            r_reject_count  <= 8'h00;
`ifdef IO_CMD_TIMEOUT_EN
            r_wait_cnt      <= '0;
`endif
        end else begin
            r_valid_q     <= valid_control_value;
            r_valid_instr <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (valid_control_value) begin
                        r_instr         <= control_value[INPUT_DATA_SIZE-1 -: INSTRUCTION_SIZE];
                        r_register      <= control_value[INPUT_DATA_SIZE-INSTRUCTION_SIZE-1 -: SIZE_WORD_REGISTER];
                        r_aux           <= control_value[AUXILIAR_SIZE-1:0];
                        r_control_ready <= 1'b0;
                        r_valid_instr   <= 1'b1;
                        r_state         <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_arm_cnt <= '0;
                    r_state   <= c_ST_ARM;
                end
                c_ST_ARM: begin
                    if (r_arm_cnt == c_ARM_LAST) begin
`ifdef IO_CMD_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (!busy_io_module) begin
                        r_result   <= result_input_io;
                        r_kind     <= w_kind;
                        r_idx      <= 4'd0;
                        r_tx_data  <= f_rsp_byte(w_kind, 4'd0, result_input_io);
                        r_tx_valid <= 1'b1;
                        r_state    <= c_ST_SEND;
                    end
`ifdef IO_CMD_TIMEOUT_EN
                    else if (r_wait_cnt == c_TO_LAST) begin
                        r_kind     <= c_RSP_TO;
                        r_idx      <= 4'd0;
                        r_tx_data  <= f_rsp_byte(c_RSP_TO, 4'd0, r_result);
                        r_tx_valid <= 1'b1;
                        r_state    <= c_ST_SEND;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                c_ST_SEND: begin
                    if (tx_ready) begin
                        if (r_idx == f_rsp_last(r_kind)) begin
                            if (r_bsy_pending) begin
                                r_bsy_pending <= 1'b0;
                                r_kind        <= c_RSP_BSY;
                                r_idx         <= 4'd0;
                                r_tx_data     <= f_rsp_byte(c_RSP_BSY, 4'd0, r_result);
                            end else begin
                                r_tx_valid      <= 1'b0;
                                r_control_ready <= 1'b1;
                                r_state         <= c_ST_IDLE;
                            end
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            r_tx_data <= f_rsp_byte(r_kind, r_idx + 4'd1, r_result);
                        end
                    end
                end
                default: begin
                    r_tx_valid      <= 1'b0;
                    r_control_ready <= 1'b1;
                    r_state         <= c_ST_IDLE;
                end
            endcase
            // A reject in the same cycle as the BSY hand-off must not be lost.
            if (w_reject) begin
                r_bsy_pending <= 1'b1;
                if (r_reject_count != 8'hFF) begin
                    r_reject_count <= r_reject_count + 8'd1;
                end
            end
        end
    end

    assign control_ready      = r_control_ready;
    assign instrucction       = r_instr;
    assign register           = r_register;
    assign auxiliar_register  = r_aux;
    assign valid_instrucction = r_valid_instr;
    assign tx_data            = r_tx_data;
    assign tx_valid           = r_tx_valid;
    assign reject_count       = r_reject_count;

endmodule
`default_nettype wire

// File: tb/tb_io_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_cmd_sequencer
// Brief    : Scoreboard bench driving an 8-bit and a 16-bit result sequencer
//            with shared command stimulus and per-instance byte queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [51:0] control_value;
    logic        valid_control_value;
    logic        busy_io_module;
    logic        tx_ready;
    logic [7:0]  result_a;
    logic [15:0] result_b;

    logic        cr_a, vi_a, txv_a, cr_b, vi_b, txv_b;
    logic [2:0]  ins_a, ins_b;
    logic [4:0]  reg_a, reg_b;
    logic [43:0] aux_a, aux_b;
    logic [7:0]  txd_a, rc_a, txd_b, rc_b;

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    int          n_pass;
    int          n_checks;
    int          hs_a;
    bit          ready_toggle;

    always #5 clk = ~clk;

    io_cmd_sequencer u_dut_a (
        .clk(clk), .rst(rst), .control_value(control_value), .valid_control_value(valid_control_value),
        .control_ready(cr_a), .instrucction(ins_a), .register(reg_a), .auxiliar_register(aux_a),
        .valid_instrucction(vi_a), .busy_io_module(busy_io_module), .result_input_io(result_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready), .reject_count(rc_a)
    );

    io_cmd_sequencer #(.IO_OUTPUT_SIZE(16), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .rst(rst), .control_value(control_value), .valid_control_value(valid_control_value),
        .control_ready(cr_b), .instrucction(ins_b), .register(reg_b), .auxiliar_register(aux_b),
        .valid_instrucction(vi_b), .busy_io_module(busy_io_module), .result_input_io(result_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready), .reject_count(rc_b)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    // Bytes are right-aligned in v, first byte most significant.
    task automatic push(input int d, input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++) begin
            if (d == 0) q_a.push_back(v[8*(n-1-i) +: 8]);
            else        q_b.push_back(v[8*(n-1-i) +: 8]);
        end
    endtask

    // Every valid cycle must present the queue head; a handshake retires it.
    task automatic mon(input int d, input logic v, input logic [7:0] data);
        logic [7:0] e;
        int         sz;
        if (!v) return;
        sz = (d == 0) ? q_a.size() : q_b.size();
        if (sz == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte_dut%0d: got %02h, required no byte", d, data);
            return;
        end
        e = (d == 0) ? q_a[0] : q_b[0];
        check($sformatf("tx_byte_dut%0d", d), {56'h0, data}, {56'h0, e});
        if (tx_ready) begin
            if (d == 0) begin
                e = q_a.pop_front();
                hs_a++;
            end else begin
                e = q_b.pop_front();
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, txv_a, txd_a);
            mon(1, txv_b, txd_b);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ready_toggle ? ~tx_ready : 1'b1;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ready_a"}, cr_a, 1);   check({tag, "_ready_b"}, cr_b, 1);
        check({tag, "_vinstr_a"}, vi_a, 0);  check({tag, "_vinstr_b"}, vi_b, 0);
        check({tag, "_txv_a"}, txv_a, 0);    check({tag, "_txv_b"}, txv_b, 0);
        check({tag, "_txd_a"}, txd_a, 0);    check({tag, "_txd_b"}, txd_b, 0);
        check({tag, "_ins_a"}, ins_a, 0);    check({tag, "_reg_a"}, reg_a, 0);
        check({tag, "_aux_a"}, aux_a, 0);    check({tag, "_ins_b"}, ins_b, 0);
        check({tag, "_rcnt_a"}, rc_a, 0);    check({tag, "_rcnt_b"}, rc_b, 0);
    endtask

    // Called just after a rising edge; returns in the cycle the first byte of dut A is valid.
    task automatic issue(input logic [2:0] op, input logic [4:0] rg, input logic [43:0] aux,
                         input int busy_n, input logic [7:0] ra, input logic [15:0] rb, input bit rej);
        control_value       = {op, rg, aux};
        valid_control_value = 1'b1;
        @(posedge clk); #1;
        valid_control_value = 1'b0;
        result_a            = ra;
        result_b            = rb;
        @(negedge clk);
        check("issue_pulse_a", vi_a, 1);
        check("issue_pulse_b", vi_b, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("issue_pulse_end_a", vi_a, 0);
        check("ctrl_ready_low_a", cr_a, 0);
        repeat (2) @(posedge clk);
        #1;
        busy_io_module = (busy_n > 0);
        for (int i = 0; i < busy_n; i++) begin
            if (rej) control_value = {3'b001, 5'd31, 44'hFFF_FFFF_FFFF};
            valid_control_value = rej && (i == 1 || i == 3);
            @(posedge clk); #1;
        end
        valid_control_value = 1'b0;
        busy_io_module      = 1'b0;
        @(negedge clk);
        check("first_byte_early_a", txv_a, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("first_byte_latency_a", txv_a, 1);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (cr_a && cr_b) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_idle: ready still low, required ready within 400 cycles", name);
        end
        check({name, "_qa_left"}, q_a.size(), 0);
        check({name, "_qb_left"}, q_b.size(), 0);
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [4:0] rg,
                       input logic [43:0] aux, input int busy_n, input logic [7:0] ra,
                       input logic [15:0] rb, input bit rej);
        @(posedge clk); #1;
        issue(op, rg, aux, busy_n, ra, rb, rej);
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  hit;
        rst = 1'b1; control_value = '0; valid_control_value = 1'b0; busy_io_module = 1'b0;
        result_a = '0; result_b = '0; tx_ready = 1'b1; ready_toggle = 1'b0;
        n_pass = 0; n_checks = 0; hs_a = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        push(0, 4, 32'h41350D0A); push(1, 6, 48'h304633430D0A);
        run("hex_a5", 3'b110, 5'd3, 44'd0, 3, 8'hA5, 16'h0F3C, 1'b0);

        ready_toggle = 1'b1;
        push(0, 4, 32'h33430D0A); push(1, 6, 48'h304633430D0A);
        run("hex_stall", 3'b110, 5'd2, 44'd0, 1, 8'h3C, 16'h0F3C, 1'b0);
        push(0, 4, 32'h4F4B0D0A); push(1, 4, 32'h4F4B0D0A);
        run("ok_stall", 3'b011, 5'd1, 44'd7, 0, 8'h00, 16'h0000, 1'b0);
        ready_toggle = 1'b0;

        push(0, 4, 32'h4F4B0D0A); push(1, 4, 32'h4F4B0D0A);
        run("write_ok", 3'b010, 5'd9, 44'h123, 2, 8'hFF, 16'hFFFF, 1'b0);
        push(0, 4, 32'h20310D0A); push(1, 4, 32'h20310D0A);
        run("bit_one", 3'b101, 5'd4, 44'd0, 0, 8'h37, 16'h0001, 1'b0);
        push(0, 4, 32'h20300D0A); push(1, 4, 32'h20300D0A);
        run("bit_zero", 3'b100, 5'd4, 44'd0, 2, 8'h36, 16'hFFFE, 1'b0);
        push(0, 4, 32'h4F4B0D0A); push(1, 4, 32'h4F4B0D0A);
        run("op111_ok", 3'b111, 5'd0, 44'd0, 1, 8'h01, 16'h0001, 1'b0);
        push(0, 4, 32'h46300D0A); push(1, 6, 48'h424445390D0A);
        run("hex_af", 3'b110, 5'd8, 44'd0, 0, 8'hF0, 16'hBDE9, 1'b0);

        push(0, 4, 32'h35410D0A); push(0, 5, 40'h4253590D0A);
        push(1, 6, 48'h313233340D0A); push(1, 5, 40'h4253590D0A);
        run("reject", 3'b110, 5'd7, 44'd5, 8, 8'h5A, 16'h1234, 1'b1);
        check("reject_count_a", rc_a, 2);
        check("reject_count_b", rc_b, 2);
        check("held_ins_a", ins_a, 3'b110);
        check("held_reg_a", reg_a, 5'd7);
        check("held_aux_a", aux_a, 44'd5);

`ifdef IO_CMD_TIMEOUT_EN
        push(0, 4, 32'h4F4B0D0A); push(1, 4, 32'h544F0D0A);
        run("timeout", 3'b010, 5'd4, 44'd9, 16, 8'h00, 16'h0000, 1'b0);
        push(0, 4, 32'h4F4B0D0A); push(1, 4, 32'h4F4B0D0A);
        run("timeout_edge", 3'b010, 5'd4, 44'd9, 15, 8'h00, 16'h0000, 1'b0);
`endif

        push(0, 4, 32'h31320D0A); push(1, 6, 48'h333435360D0A);
        base = hs_a;
        hit  = 1'b0;
        @(posedge clk); #1;
        issue(3'b110, 5'd1, 44'd0, 0, 8'h12, 16'h3456, 1'b0);
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #2;
            if (hs_a >= base + 2) hit = 1'b1;
        end
        check("rst_two_bytes_sent", hit, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("mid_send_rst");
        q_a.delete();
        q_b.delete();
        push(0, 4, 32'h4F4B0D0A); push(1, 4, 32'h4F4B0D0A);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(3'b010, 5'd2, 44'd1, 0, 8'h00, 16'h0000, 1'b0);
        wait_idle("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_cmd_sequencer.md
# io_cmd_sequencer

Parametrised command sequencer between the command decoder and the IO module / UART byte sender. It accepts a decoded control word and issues the instruction to the IO module. It waits for completion, then streams an ASCII response line byte-by-byte with a valid/ready handshake. Generalises the fixed 32-bit/4-byte response path to any IO result width, with explicit backpressure, busy-reject queuing and an optional IO timeout.

## Interface
- `INPUT_DATA_SIZE`, 52, control word width
- `INSTRUCTION_SIZE`, 3, opcode field width (control word MSBs)
- `SIZE_WORD_REGISTER`, 5, register field width (below opcode)
- `AUXILIAR_SIZE`, `INPUT_DATA_SIZE-INSTRUCTION_SIZE-SIZE_WORD_REGISTER`, auxiliary field (LSBs)
- `IO_OUTPUT_SIZE`, 8, IO result width; multiple of 4, 4..32
- `ARM_CYCLES`, 2, cycles after issue during which `busy_io_module` is ignored; ≥1
- `TIMEOUT_CYCLES`, 1024, WAIT-state limit (timeout build only)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `control_value`  in  INPUT_DATA_SIZE  command word
- `valid_control_value`  in  1  command present
- `control_ready`  out  1  high in IDLE; command accepted on valid&ready
- `instrucction`  out  INSTRUCTION_SIZE  latched opcode
- `register`  out  SIZE_WORD_REGISTER  latched register field
- `auxiliar_register`  out  AUXILIAR_SIZE  latched auxiliary field
- `valid_instrucction`  out  1  one-cycle issue pulse to IO module
- `busy_io_module`  in  1  IO module busy
- `result_input_io`  in  IO_OUTPUT_SIZE  IO result, sampled at completion
- `tx_data`  out  8  response byte
- `tx_valid`  out  1  byte valid
- `tx_ready`  in  1  sender accepts byte
- `reject_count`  out  8  saturating count of rejected commands

## Operation
- States: IDLE → ISSUE → ARM → WAIT → SEND → IDLE.
- IDLE:
  - `control_ready`=1.
  - On `valid_control_value`, latch the opcode/register/aux fields from the MSB downward.
  - Next state ISSUE.
- ISSUE: `valid_instrucction`=1 for exactly one cycle, then ARM.
- ARM: hold ARM_CYCLES cycles, then WAIT.
- WAIT:
  - First cycle with `busy_io_module`=0: capture `result_input_io`, select the response, go to SEND.
- Responses (ASCII):
  - Opcode MSB=0 or 3'b111: "OK\r\n" (4F 4B 0D 0A).
  - 3'b110: IO_OUTPUT_SIZE/4 hex digits, most-significant nibble first, uppercase (0-9→30-39, A-F→41-46), then 0D 0A.
  - 3'b100/3'b101: 20 30 0D 0A if result bit0=0, else 20 31 0D 0A.
  - Timeout: "TO\r\n" (54 4F 0D 0A).
  - Busy: "BSY\r\n" (42 53 59 0D 0A).
- SEND:
  - Byte index advances only on `tx_valid`&`tx_ready`.
  - After the last byte's handshake: if `bsy_pending`, emit the busy line and clear the flag; then IDLE.
- Command presented while not IDLE:
  - Not accepted; latched fields unchanged.
  - Sets `bsy_pending` once per rejected valid cycle run (rising edge of valid while not ready).
  - Increments `reject_count`, saturating at 255.
  - Multiple rejects during one transaction produce a single BSY line.
- Latched fields hold until the next accept.

## Timing
- Reset values: `control_ready`=1, `valid_instrucction`=0, `tx_valid`=0, `tx_data`=0, `instrucction`/`register`/`auxiliar_register`=0, `reject_count`=0, `bsy_pending`=0; state IDLE.
- Reset mid-transaction:
  - Aborts on the next edge, with no further bytes.
  - `tx_valid` drops in the cycle after `rst` is sampled.
- Accept at edge T: `valid_instrucction`=1 during T+1; ARM during T+2..T+1+ARM_CYCLES.
- Earliest completion sample at T+2+ARM_CYCLES; `tx_valid` rises the next cycle.
- ARM_CYCLES=2: busy low at T+4 → first byte valid at T+5.
- `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
- Back-to-back bytes: with `tx_ready` held high, one byte per cycle.
- `control_ready` returns 1 the cycle after the final handshake. A pending BSY line is sent first, contiguously.
- `busy_io_module` is ignored outside WAIT.

## Configuration
- `IO_CMD_TIMEOUT_EN` defined:
  - WAIT counter starts at 0 on entry.
  - If `busy_io_module` is still 1 after TIMEOUT_CYCLES WAIT cycles, capture nothing and send "TO\r\n".
  - Completion in the final counted cycle takes priority over timeout.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - `TIMEOUT_CYCLES` unused.

## Test plan
- Reset then opcode 3'b110, register 5'd3, IO busy 3 cycles, result 8'hA5, `tx_ready`=1 → `valid_instrucction` pulse one cycle; bytes 41 35 0D 0A; `control_ready` back high.
- IO_OUTPUT_SIZE=16, opcode 3'b110, result 16'h0F3C, `tx_ready` toggled 1/0 → bytes 30 46 33 43 0D 0A, each held stable under stall, no duplicates.
- Opcode 3'b010 (write) → 4F 4B 0D 0A. Opcode 3'b101, result bit0=1 → 20 31 0D 0A.
- Two separate command pulses during WAIT → `reject_count`=2, main response then exactly one 42 53 59 0D 0A; latched fields unchanged.
- With `IO_CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=16, busy held high → 54 4F 0D 0A. Busy low exactly on cycle 16 → normal response.
- Assert `rst` mid-SEND after 2 bytes → `tx_valid`=0 next cycle, all outputs at reset values, new command accepted immediately after release.
